// File: rtl/random_pixel_writer_pkg.sv
// Shared definitions for the random pixel writer and related framebuffer
// animators: FSM state encoding, matrix geometry and the column-width helper.
package random_pixel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } state_t;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;

  // Bits needed to address every column across the device chain.
  function automatic int col_bits(input int num_devices);
    return $clog2(MATRIX_COLS * num_devices);
  endfunction

endpackage

// File: rtl/random_pixel_writer_if.sv
// Framebuffer pixel-write channel (valid/ready handshake).
//   Valid  master->slave  write request
//   Ready  slave->master  write accepted when Valid & Ready
//   Row    master->slave  pixel row 0..7
//   Col    master->slave  pixel column
//   Pixel  master->slave  pixel value
interface random_pixel_writer_if
  import random_pixel_pkg::*;
#(
  parameter int COL_BITS = 5
);
  logic                           Valid;
  logic                           Ready;
  logic [$clog2(MATRIX_ROWS)-1:0] Row;
  logic [COL_BITS-1:0]            Col;
  logic                           Pixel;

  modport master (output Valid, Row, Col, Pixel, input Ready);
  modport slave  (input Valid, Row, Col, Pixel, output Ready);
endinterface

// File: rtl/random_pixel_writer_tick_divider.sv
// tick_divider: free-running prescaler producing a one-cycle tick every
// PERIOD_CYCLES enabled clocks. Disabling freezes the count without clearing.
//   i_Clk     system clock
//   i_Reset   synchronous, active-high; clears the count
//   i_Enable  count enable
//   o_Tick    high for the single cycle at count PERIOD_CYCLES-1 while enabled
module tick_divider #(
  parameter int PERIOD_CYCLES = 100000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Enable,
  output logic o_Tick
);
  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);
  // Gated by the enable so a frozen count sitting at LAST cannot re-fire.
  assign o_Tick    = i_Enable && w_at_last;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_count <= '0;
    end else if (i_Enable) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end
endmodule

// File: rtl/random_pixel_writer.sv
// random_pixel_writer: on each prescaler tick, steps the LFSR generator,
// splits its output into row/column/pixel and issues one framebuffer write,
// producing a random sparkle pattern across the chained 8x8 matrices.
//   i_Clk, i_Reset   clock, synchronous active-high reset
//   i_Run            level enable for the prescaler
//   o_Random_Enable  one-cycle generator step pulse
//   i_Random_Data    generator output, valid one clock after the step pulse
//   o_Wr             framebuffer write channel (master side)
//   o_Pixel_Count    number of accepted writes (wraps)
//   o_Overrun        sticky: a tick arrived while a draw was still in flight
module random_pixel_writer
  import random_pixel_pkg::*;
#(
  parameter int NUM_BITS      = 16,
  parameter int NUM_DEVICES   = 4,
  parameter int PERIOD_CYCLES = 100000
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Run,
  output logic                  o_Random_Enable,
  input  logic [NUM_BITS-1:0]   i_Random_Data,
  random_pixel_writer_if.master o_Wr,
  output logic [15:0]           o_Pixel_Count,
  output logic                  o_Overrun
);
  localparam int COL_BITS = col_bits(NUM_DEVICES);
  localparam int NUM_COLS = MATRIX_COLS * NUM_DEVICES;

  if (NUM_BITS < COL_BITS + 4) begin : g_bad_num_bits
    $error("NUM_BITS must be at least COL_BITS+4");
  end
  if (PERIOD_CYCLES < 4) begin : g_bad_period
    $error("PERIOD_CYCLES must be at least 4");
  end

  state_t              r_state;
  state_t              w_next;
  logic                w_tick;
  logic                w_accept;
  logic                w_col_ok;
  logic [COL_BITS-1:0] w_col;
  logic [2:0]          r_row;
  logic [COL_BITS-1:0] r_col;
  logic                r_pixel;
  logic [15:0]         r_count;
  logic                r_overrun;
  logic                w_unused;

  tick_divider #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Enable(i_Run),
    .o_Tick  (w_tick)
  );

  assign w_col    = i_Random_Data[3 +: COL_BITS];
  // Column field can exceed the chain width when it is not a power of two.
  assign w_col_ok = (int'(w_col) < NUM_COLS);
  assign w_accept = (r_state == WRITE) && o_Wr.Ready;
  // Bits above the pixel bit are deliberately ignored.
  assign w_unused = ^i_Random_Data;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_tick) w_next = STEP;
      STEP:    w_next = CAPTURE;
      CAPTURE: w_next = w_col_ok ? WRITE : STEP;
      WRITE:   if (w_accept) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_row     <= '0;
      r_col     <= '0;
      r_pixel   <= 1'b0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == CAPTURE) begin
        r_row   <= i_Random_Data[2:0];
        r_col   <= w_col;
        r_pixel <= i_Random_Data[3 + COL_BITS];
      end
      if (w_accept) r_count <= r_count + 16'd1;
      // Includes a tick landing on the accept cycle: FSM is still in WRITE.
      if (w_tick && (r_state != IDLE)) r_overrun <= 1'b1;
    end
  end

  assign o_Random_Enable = (r_state == STEP);
  assign o_Wr.Valid      = (r_state == WRITE);
  assign o_Wr.Row        = r_row;
  assign o_Wr.Col        = r_col;
  assign o_Wr.Pixel      = r_pixel;
  assign o_Pixel_Count   = r_count;
  assign o_Overrun       = r_overrun;
endmodule

// File: tb/tb_random_pixel_writer.sv
// Directed bench for random_pixel_writer: dut_a uses 4 devices, dut_b uses
// 3 devices to exercise the out-of-range column redraw path.
module tb_random_pixel_writer;
  import random_pixel_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- dut_a : NUM_DEVICES = 4 ----------------
  logic        rst_a, run_a, en_a, ovr_a;
  logic [15:0] data_a = 16'h0000;
  logic [15:0] nxt_a  = 16'h0000;
  logic [15:0] cnt_a;
  int          ena_cnt = 0;
  random_pixel_writer_if #(.COL_BITS(5)) wa ();

  random_pixel_writer #(.NUM_BITS(16), .NUM_DEVICES(4), .PERIOD_CYCLES(4)) dut_a (
    .i_Clk(clk), .i_Reset(rst_a), .i_Run(run_a), .o_Random_Enable(en_a),
    .i_Random_Data(data_a), .o_Wr(wa), .o_Pixel_Count(cnt_a), .o_Overrun(ovr_a)
  );

  // Generator model: new value one clock after each step pulse.
  always @(posedge clk) begin
    if (en_a) begin
      data_a  <= nxt_a;
      ena_cnt <= ena_cnt + 1;
    end
  end

  // ---------------- dut_b : NUM_DEVICES = 3 ----------------
  logic        rst_b, run_b, en_b, ovr_b;
  logic [15:0] data_b = 16'h0000;
  logic [15:0] cnt_b;
  logic [15:0] seq_b [2];
  int          idx_b   = 0;
  int          enb_cnt = 0;
  random_pixel_writer_if #(.COL_BITS(5)) wb ();

  random_pixel_writer #(.NUM_BITS(16), .NUM_DEVICES(3), .PERIOD_CYCLES(4)) dut_b (
    .i_Clk(clk), .i_Reset(rst_b), .i_Run(run_b), .o_Random_Enable(en_b),
    .i_Random_Data(data_b), .o_Wr(wb), .o_Pixel_Count(cnt_b), .o_Overrun(ovr_b)
  );

  always @(posedge clk) begin
    if (en_b) begin
      if (idx_b < 2) data_b <= seq_b[idx_b];
      idx_b   <= idx_b + 1;
      enb_cnt <= enb_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en_a(output int n);
    n = 0;
    while (en_a !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("en_a_seen", {31'd0, en_a}, 32'd1);
  endtask

  int n;
  int base;

  initial begin
    rst_a = 1'b1; run_a = 1'b1; wa.Ready = 1'b0; nxt_a = 16'h0125;
    rst_b = 1'b1; run_b = 1'b0; wb.Ready = 1'b0;
    seq_b[0] = 16'h00F8; seq_b[1] = 16'h0125;

    // 1: reset held 3 clocks with run high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_enable", {31'd0, en_a}, 32'd0);
      chk("rst_valid", {31'd0, wa.Valid}, 32'd0);
    end
    chk("rst_count", {16'd0, cnt_a}, 32'd0);
    chk("rst_overrun", {31'd0, ovr_a}, 32'd0);
    chk("rst_row", {29'd0, wa.Row}, 32'd0);
    chk("rst_col", {27'd0, wa.Col}, 32'd0);
    chk("rst_pixel", {31'd0, wa.Pixel}, 32'd0);

    // 2: single draw, ready already high (ignored while not valid)
    wa.Ready = 1'b1;
    rst_a = 1'b0;
    wait_en_a(n);
    chk("first_enable_latency", n, 32'd4);
    step();
    chk("enable_one_cycle", {31'd0, en_a}, 32'd0);
    chk("capture_no_valid", {31'd0, wa.Valid}, 32'd0);
    step();
    chk("write_valid", {31'd0, wa.Valid}, 32'd1);
    chk("write_row", {29'd0, wa.Row}, 32'd5);
    chk("write_col", {27'd0, wa.Col}, 32'd4);
    chk("write_pixel", {31'd0, wa.Pixel}, 32'd1);
    chk("count_before_accept", {16'd0, cnt_a}, 32'd0);
    step();
    chk("valid_drops_after_accept", {31'd0, wa.Valid}, 32'd0);
    chk("count_after_accept", {16'd0, cnt_a}, 32'd1);
    chk("no_overrun_back_to_back", {31'd0, ovr_a}, 32'd0);

    // 3/4: stall 5 clocks across a tick
    nxt_a = 16'h0A3A;
    wa.Ready = 1'b0;
    base = ena_cnt;
    wait_en_a(n);
    chk("next_enable_latency", n, 32'd1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, wa.Valid}, 32'd1);
      chk("stall_row", {29'd0, wa.Row}, 32'd2);
      chk("stall_col", {27'd0, wa.Col}, 32'd7);
      chk("stall_pixel", {31'd0, wa.Pixel}, 32'd0);
      chk("stall_count", {16'd0, cnt_a}, 32'd1);
      if (i < 4) step();
    end
    chk("overrun_set", {31'd0, ovr_a}, 32'd1);
    chk("no_extra_enable", ena_cnt - base, 32'd1);
    wa.Ready = 1'b1;
    step();
    chk("stall_accept_valid", {31'd0, wa.Valid}, 32'd0);
    chk("stall_accept_count", {16'd0, cnt_a}, 32'd2);

    // Run drop while busy: current draw completes, nothing further
    step();
    chk("draw_after_stall", {31'd0, en_a}, 32'd1);
    run_a = 1'b0;
    base = ena_cnt;
    step();
    step();
    step();
    chk("run_drop_completes", {16'd0, cnt_a}, 32'd3);
    for (int i = 0; i < 8; i++) step();
    chk("run_drop_no_enable", ena_cnt - base, 32'd1);
    chk("overrun_sticky", {31'd0, ovr_a}, 32'd1);

    // 6: reset while valid and not ready
    wa.Ready = 1'b0;
    run_a = 1'b1;
    n = 0;
    while (wa.Valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("reach_write", {31'd0, wa.Valid}, 32'd1);
    rst_a = 1'b1;
    step();
    chk("midrst_valid", {31'd0, wa.Valid}, 32'd0);
    chk("midrst_count", {16'd0, cnt_a}, 32'd0);
    chk("midrst_overrun", {31'd0, ovr_a}, 32'd0);
    rst_a = 1'b0;
    wa.Ready = 1'b1;
    nxt_a = 16'h0125;
    wait_en_a(n);
    chk("restart_latency", n, 32'd4);
    step();
    step();
    chk("restart_valid", {31'd0, wa.Valid}, 32'd1);
    chk("restart_col", {27'd0, wa.Col}, 32'd4);
    step();
    chk("restart_count", {16'd0, cnt_a}, 32'd1);
    run_a = 1'b0;

    // 5: redraw on out-of-range column (3 devices)
    step();
    rst_b = 1'b0;
    run_b = 1'b1;
    wb.Ready = 1'b1;
    base = enb_cnt;
    n = 0;
    while (wb.Valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("redraw_valid", {31'd0, wb.Valid}, 32'd1);
    chk("redraw_enables", enb_cnt - base, 32'd2);
    chk("redraw_row", {29'd0, wb.Row}, 32'd5);
    chk("redraw_col", {27'd0, wb.Col}, 32'd4);
    chk("redraw_pixel", {31'd0, wb.Pixel}, 32'd1);
    chk("redraw_no_early_write", {16'd0, cnt_b}, 32'd0);
    chk("redraw_overrun", {31'd0, ovr_b}, 32'd1);
    step();
    chk("redraw_count", {16'd0, cnt_b}, 32'd1);
    chk("redraw_valid_drop", {31'd0, wb.Valid}, 32'd0);
    run_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
